// File: rtl/mips_exc_pkg.sv
// mips_exc_pkg
// Shared definitions for address-exception checking:
//   - ExcCode values for load/store address errors
//   - exception-bus layout (valid bit index for the default width)
//   - access-size encodings and a word-size helper
//   - default address-map constants (DM window, device window, read-only word)
package mips_exc_pkg;

    localparam int          EXC_W_DEF       = 6;
    localparam int          EXC_VLD_BIT_DEF = EXC_W_DEF - 1;

    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [4:0]  EXC_ADES = 5'd5;

    localparam logic [1:0]  SIZE_BYTE = 2'd0;
    localparam logic [1:0]  SIZE_HALF = 2'd1;
    localparam logic [1:0]  SIZE_WORD = 2'd2;

    localparam logic [31:0] DM_LIMIT_DEF    = 32'h0000_1FFF;
    localparam logic [31:0] DEV_BASE_DEF    = 32'h0000_7F00;
    localparam logic [31:0] DEV_LIMIT_DEF   = 32'h0000_7F47;
    localparam int          DEV_RO_WORD_DEF = 2;

    // Encoding 3 is illegal and behaves as a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/addr_map_check.sv
// addr_map_check
// Purely combinational address-map legality check, reusable for fetch.
// Ports:
//   addr     in  32  byte address
//   size     in  2   0=byte, 1=half, 2/3=word
//   is_store in  1   access is a store (enables the read-only rule)
//   fault    out 1   misaligned, unmapped, sub-word device, or RO store
module addr_map_check
    import mips_exc_pkg::*;
#(
    parameter logic [31:0] DM_LIMIT    = DM_LIMIT_DEF,
    parameter logic [31:0] DEV_BASE    = DEV_BASE_DEF,
    parameter logic [31:0] DEV_LIMIT   = DEV_LIMIT_DEF,
    parameter int          DEV_RO_WORD = DEV_RO_WORD_DEF
) (
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        is_store,
    output logic        fault
);

    logic in_dm;
    logic in_dev;
    logic mis;
    logic ro_hit;
    logic [1:0] ro_word;

    assign ro_word = DEV_RO_WORD[1:0];
    assign in_dm   = (addr <= DM_LIMIT);
    assign in_dev  = (addr >= DEV_BASE) && (addr <= DEV_LIMIT);
    assign mis     = ((size == SIZE_HALF) && addr[0]) ||
                     (is_word(size) && (addr[1:0] != 2'b00));
    assign ro_hit  = is_store && in_dev && (addr[3:2] == ro_word);

    // Devices only accept full-word accesses.
    assign fault = mis || !(in_dm || in_dev) || (in_dev && !is_word(size)) || ro_hit;

endmodule

// File: rtl/mem_addr_exc_stage.sv
// mem_addr_exc_stage
// Registered E->M stage that flags load/store address errors (AdEL/AdES),
// gates memory enables on any pending exception, captures BadVAddr with an
// ack handshake and keeps a saturating fault counter.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   stall, flush             hold M registers / insert bubble into M
//   valid_e, is_load_e, is_store_e, size_e, addr_e, exc_e   E-side access
//   exc_m, addr_m, mem_we_m, mem_re_m                        M-side outputs
//   badv_valid, badvaddr, badv_ack                           BadVAddr to CP0
//   fault_cnt                                                fault counter
module mem_addr_exc_stage
    import mips_exc_pkg::*;
#(
    parameter int          EXC_W       = EXC_W_DEF,
    parameter logic [31:0] DM_LIMIT    = DM_LIMIT_DEF,
    parameter logic [31:0] DEV_BASE    = DEV_BASE_DEF,
    parameter logic [31:0] DEV_LIMIT   = DEV_LIMIT_DEF,
    parameter int          DEV_RO_WORD = DEV_RO_WORD_DEF,
    parameter int          FCNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_e,
    input  logic              is_load_e,
    input  logic              is_store_e,
    input  logic [1:0]        size_e,
    input  logic [31:0]       addr_e,
    input  logic [EXC_W-1:0]  exc_e,
    output logic [EXC_W-1:0]  exc_m,
    output logic [31:0]       addr_m,
    output logic              mem_we_m,
    output logic              mem_re_m,
    output logic              badv_valid,
    output logic [31:0]       badvaddr,
    input  logic              badv_ack,
    output logic [FCNT_W-1:0] fault_cnt
);

    logic             fault;
    logic             fault_hit;
    logic             new_fault;
    logic [EXC_W-1:0] exc_next;

    addr_map_check #(
        .DM_LIMIT    (DM_LIMIT),
        .DEV_BASE    (DEV_BASE),
        .DEV_LIMIT   (DEV_LIMIT),
        .DEV_RO_WORD (DEV_RO_WORD)
    ) u_check (
        .addr     (addr_e),
        .size     (size_e),
        .is_store (is_store_e),
        .fault    (fault)
    );

    // An earlier-stage exception wins and suppresses the address check.
    // A malformed load+store request takes the store path.
    always_comb begin
        exc_next  = exc_e;
        fault_hit = 1'b0;
        if (!exc_e[EXC_W-1] && valid_e && fault && (is_store_e || is_load_e)) begin
            fault_hit           = 1'b1;
            exc_next            = '0;
            exc_next[EXC_W-1]   = 1'b1;
            exc_next[4:0]       = is_store_e ? EXC_ADES : EXC_ADEL;
        end
    end

    assign new_fault = fault_hit && !flush && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_m      <= '0;
            addr_m     <= '0;
            mem_we_m   <= 1'b0;
            mem_re_m   <= 1'b0;
            badv_valid <= 1'b0;
            badvaddr   <= '0;
            fault_cnt  <= '0;
        end else begin
            if (flush) begin
                exc_m    <= '0;
                addr_m   <= '0;
                mem_we_m <= 1'b0;
                mem_re_m <= 1'b0;
            end else if (!stall) begin
                exc_m    <= exc_next;
                addr_m   <= addr_e;
                mem_we_m <= valid_e && is_store_e && !exc_next[EXC_W-1];
                mem_re_m <= valid_e && is_load_e && !is_store_e && !exc_next[EXC_W-1];
            end

            // An unacknowledged address is never overwritten; an ack in the
            // same cycle as a new fault hands the slot straight to the new one.
            if (new_fault && (!badv_valid || badv_ack)) begin
                badvaddr   <= addr_e;
                badv_valid <= 1'b1;
            end else if (badv_ack) begin
                badv_valid <= 1'b0;
            end

            if (new_fault && (fault_cnt != '1))
                fault_cnt <= fault_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_addr_exc_stage.sv
module tb_mem_addr_exc_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, valid_e, is_load_e, is_store_e, badv_ack;
    logic [1:0]  size_e;
    logic [31:0] addr_e;
    logic [5:0]  exc_e;

    logic [5:0]  exc_m, exc_m2;
    logic [31:0] addr_m, addr_m2, badvaddr, badvaddr2;
    logic        we, re, we2, re2, bv, bv2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    // reference state
    logic [5:0]  r_exc;
    logic [31:0] r_addr, r_bva;
    logic        r_we, r_re, r_bv;
    int          r_cnt, r_cnt2;

    always #5 clk = ~clk;

    mem_addr_exc_stage #(.FCNT_W(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_e(valid_e), .is_load_e(is_load_e), .is_store_e(is_store_e),
        .size_e(size_e), .addr_e(addr_e), .exc_e(exc_e),
        .exc_m(exc_m), .addr_m(addr_m), .mem_we_m(we), .mem_re_m(re),
        .badv_valid(bv), .badvaddr(badvaddr), .badv_ack(badv_ack), .fault_cnt(cnt)
    );

    mem_addr_exc_stage #(.FCNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .valid_e(valid_e), .is_load_e(is_load_e), .is_store_e(is_store_e),
        .size_e(size_e), .addr_e(addr_e), .exc_e(exc_e),
        .exc_m(exc_m2), .addr_m(addr_m2), .mem_we_m(we2), .mem_re_m(re2),
        .badv_valid(bv2), .badvaddr(badvaddr2), .badv_ack(badv_ack), .fault_cnt(cnt2)
    );

    // Address-map rules stated as plain arithmetic on the byte address.
    function automatic bit ref_fault(input logic [31:0] a, input int sz, input bit st);
        int unsigned align;
        bit in_dm, in_dev;
        align  = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        in_dm  = (a <= 32'h1FFF);
        in_dev = (a >= 32'h7F00) && (a <= 32'h7F47);
        if ((a % align) != 0) return 1;
        if (!in_dm && !in_dev) return 1;
        if (in_dev && align != 4) return 1;
        if (st && in_dev && ((a / 4) % 4) == 2) return 1;
        return 0;
    endfunction

    task automatic model_step();
        bit f, nf;
        logic [5:0] code;
        if (reset) begin
            r_exc = 0; r_addr = 0; r_we = 0; r_re = 0;
            r_bv = 0; r_bva = 0; r_cnt = 0; r_cnt2 = 0;
            return;
        end
        f = valid_e && (is_load_e || is_store_e) && !exc_e[5] &&
            ref_fault(addr_e, int'(size_e), is_store_e);
        code = !f ? exc_e : (is_store_e ? 6'h25 : 6'h24);
        nf = f && !flush && !stall;
        if (flush) begin
            r_exc = 0; r_addr = 0; r_we = 0; r_re = 0;
        end else if (!stall) begin
            r_exc  = code;
            r_addr = addr_e;
            r_we   = valid_e && is_store_e && !code[5];
            r_re   = valid_e && is_load_e && !is_store_e && !code[5];
        end
        if (nf && (!r_bv || badv_ack)) begin
            r_bv = 1; r_bva = addr_e;
        end else if (badv_ack) begin
            r_bv = 0;
        end
        if (nf) begin
            if (r_cnt < 65535) r_cnt++;
            if (r_cnt2 < 3) r_cnt2++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        reset = 0; stall = 0; flush = 0; valid_e = 0; is_load_e = 0;
        is_store_e = 0; size_e = 0; addr_e = 0; exc_e = 0; badv_ack = 0;
    endtask

    task automatic acc(input bit ld, input bit st, input logic [1:0] sz,
                       input logic [31:0] a, input logic [5:0] ex, input bit ack);
        idle();
        valid_e = 1; is_load_e = ld; is_store_e = st; size_e = sz;
        addr_e = a; exc_e = ex; badv_ack = ack;
        tick();
        idle();
    endtask

    task automatic do_reset();
        idle(); reset = 1; tick(); reset = 0;
    endtask

    task automatic test_reset();
        idle(); valid_e = 1; is_load_e = 1; addr_e = 32'h1; size_e = 1;
        reset = 1; tick(); idle();
        n_cmp++;
        if ({exc_m, addr_m, we, re, bv, badvaddr, cnt, cnt2} !== '0) begin
            n_bad++;
            $display("FAIL reset: got exc=%h addr=%h we=%b re=%b bv=%b bva=%h cnt=%0d cnt2=%0d, want all 0",
                     exc_m, addr_m, we, re, bv, badvaddr, cnt, cnt2);
        end
    endtask

    task automatic test_legal();
        acc(1, 0, 2, 32'h1FFC, 0, 0);
        n_cmp++;
        if (exc_m !== 6'h00 || re !== 1'b1 || we !== 1'b0 || addr_m !== 32'h1FFC) begin
            n_bad++; $display("FAIL legal_lw: exc=%h re=%b we=%b addr=%h, want 00 1 0 1ffc", exc_m, re, we, addr_m);
        end
        acc(0, 1, 2, 32'h7F04, 0, 0);
        n_cmp++;
        if (exc_m !== 6'h00 || we !== 1'b1 || re !== 1'b0) begin
            n_bad++; $display("FAIL legal_sw: exc=%h we=%b re=%b, want 00 1 0", exc_m, we, re);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        acc(1, 0, 1, 32'h1, 0, 0);
        n_cmp++;
        if (exc_m !== 6'b100100 || re !== 1'b0 || badvaddr !== 32'h1 || bv !== 1'b1 || cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL misaligned_lh: exc=%b re=%b bva=%h bv=%b cnt=%0d, want 100100 0 1 1 1",
                     exc_m, re, badvaddr, bv, cnt);
        end
    endtask

    task automatic test_device();
        logic [31:0] a [4] = '{32'h7F00, 32'h7F08, 32'h7F08, 32'h7F48};
        bit          s [4] = '{1, 1, 0, 0};
        logic [1:0]  z [4] = '{0, 2, 2, 2};
        logic [5:0]  w [4] = '{6'b100101, 6'b100101, 6'b000000, 6'b100100};
        for (int i = 0; i < 4; i++) begin
            acc(!s[i], s[i], z[i], a[i], 0, 0);
            n_cmp++;
            if (exc_m !== w[i]) begin
                n_bad++; $display("FAIL device_%0d: addr=%h exc=%b, want %b", i, a[i], exc_m, w[i]);
            end
        end
    endtask

    task automatic test_gap_pass();
        logic [31:0] bva0;
        logic [15:0] cnt0;
        acc(1, 0, 2, 32'h2000, 0, 0);
        n_cmp++;
        if (exc_m !== 6'b100100) begin
            n_bad++; $display("FAIL gap_lw: exc=%b, want 100100", exc_m);
        end
        bva0 = badvaddr; cnt0 = cnt;
        acc(1, 0, 2, 32'h3, 6'b101010, 0);
        n_cmp++;
        if (exc_m !== 6'b101010 || badvaddr !== bva0 || cnt !== cnt0 || re !== 1'b0) begin
            n_bad++; $display("FAIL passthru: exc=%b bva=%h cnt=%0d re=%b, want 101010 %h %0d 0",
                              exc_m, badvaddr, cnt, re, bva0, cnt0);
        end
    endtask

    task automatic test_badv();
        do_reset();
        acc(1, 0, 2, 32'h5, 0, 0);
        acc(1, 0, 2, 32'h9, 0, 0);
        n_cmp++;
        if (badvaddr !== 32'h5 || bv !== 1'b1 || cnt !== 16'd2) begin
            n_bad++; $display("FAIL badv_hold: bva=%h bv=%b cnt=%0d, want 5 1 2", badvaddr, bv, cnt);
        end
        acc(1, 0, 2, 32'hD, 0, 1);
        n_cmp++;
        if (badvaddr !== 32'hD || bv !== 1'b1) begin
            n_bad++; $display("FAIL badv_ack_fault: bva=%h bv=%b, want d 1", badvaddr, bv);
        end
        idle(); badv_ack = 1; tick(); idle();
        n_cmp++;
        if (bv !== 1'b0 || badvaddr !== 32'hD) begin
            n_bad++; $display("FAIL badv_ack: bv=%b bva=%h, want 0 d", bv, badvaddr);
        end
    endtask

    task automatic test_stall_flush();
        logic [5:0] e0; logic [31:0] a0; logic w0, rd0;
        logic [15:0] c0;
        acc(0, 1, 2, 32'h10, 0, 0);
        e0 = exc_m; a0 = addr_m; w0 = we; rd0 = re; c0 = cnt;
        for (int i = 0; i < 3; i++) begin
            idle(); stall = 1; valid_e = 1; is_load_e = 1; size_e = 1;
            addr_e = 32'h41 + i; tick();
            n_cmp++;
            if (exc_m !== e0 || addr_m !== a0 || we !== w0 || re !== rd0 || cnt !== c0) begin
                n_bad++; $display("FAIL stall_%0d: exc=%h addr=%h we=%b re=%b cnt=%0d, want %h %h %b %b %0d",
                                  i, exc_m, addr_m, we, re, cnt, e0, a0, w0, rd0, c0);
            end
        end
        idle(); stall = 1; flush = 1; valid_e = 1; is_store_e = 1; size_e = 2;
        addr_e = 32'h3; tick(); idle();
        n_cmp++;
        if (exc_m !== 6'h0 || addr_m !== 32'h0 || we !== 1'b0 || re !== 1'b0 || cnt !== c0) begin
            n_bad++; $display("FAIL flush_stall: exc=%h addr=%h we=%b re=%b cnt=%0d, want 0 0 0 0 %0d",
                              exc_m, addr_m, we, re, cnt, c0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        acc(1, 0, 2, 32'h2, 0, 0);
        acc(0, 1, 2, 32'h7F08, 0, 0);
        n_cmp++;
        if (cnt !== 16'd2) begin
            n_bad++; $display("FAIL pre_reset_cnt: cnt=%0d, want 2", cnt);
        end
        idle(); reset = 1; valid_e = 1; is_load_e = 1; size_e = 2; addr_e = 32'h7;
        tick(); idle();
        n_cmp++;
        if ({exc_m, addr_m, we, re, bv, badvaddr, cnt} !== '0) begin
            n_bad++; $display("FAIL reset_mid: exc=%h addr=%h we=%b re=%b bv=%b bva=%h cnt=%0d, want 0",
                              exc_m, addr_m, we, re, bv, badvaddr, cnt);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 5; i++) acc(1, 0, 2, 32'h1 + 4 * i, 0, 0);
        n_cmp++;
        if (cnt2 !== 2'd3 || cnt !== 16'd5) begin
            n_bad++; $display("FAIL saturate: cnt2=%0d cnt=%0d, want 3 5", cnt2, cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int op, sel;
            idle();
            reset    = ($urandom_range(0, 49) == 0);
            stall    = ($urandom_range(0, 7) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            badv_ack = ($urandom_range(0, 3) == 0);
            valid_e  = ($urandom_range(0, 5) != 0);
            op = $urandom_range(0, 2);
            is_load_e  = (op == 1);
            is_store_e = (op == 2);
            size_e = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 3);
            case (sel)
                0: addr_e = 32'($urandom_range(0, 32'h2003));
                1: addr_e = 32'($urandom_range(32'h7EF8, 32'h7F4F));
                2: addr_e = 32'($urandom_range(32'h1FF0, 32'h200F));
                default: addr_e = $urandom;
            endcase
            exc_e = ($urandom_range(0, 7) == 0) ? {1'b1, 5'($urandom)} : 6'($urandom_range(0, 31));
            tick();
            n_cmp++;
            if (exc_m !== r_exc || addr_m !== r_addr || we !== r_we || re !== r_re) begin
                n_bad++; $display("FAIL rand_m[%0d]: exc=%h addr=%h we=%b re=%b, want %h %h %b %b",
                                  i, exc_m, addr_m, we, re, r_exc, r_addr, r_we, r_re);
            end
            n_cmp++;
            if (bv !== r_bv || (r_bv && badvaddr !== r_bva) || int'(cnt) != r_cnt || int'(cnt2) != r_cnt2) begin
                n_bad++; $display("FAIL rand_badv[%0d]: bv=%b bva=%h cnt=%0d cnt2=%0d, want %b %h %0d %0d",
                                  i, bv, badvaddr, cnt, cnt2, r_bv, r_bva, r_cnt, r_cnt2);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        r_exc = 0; r_addr = 0; r_we = 0; r_re = 0; r_bv = 0; r_bva = 0; r_cnt = 0; r_cnt2 = 0;
        test_reset();
        test_legal();
        test_misaligned();
        test_device();
        test_gap_pass();
        test_badv();
        test_stall_flush();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
